// File: rtl/perm_step_counter.sv
// Timing responder for the bit-serial permutation controller: per-phase bit
// counter, saturating round counter and MSB-first round-constant serializer.
module perm_step_counter #(
  parameter int CNT_W      = 6,
  parameter int RND_W      = 4,
  parameter int MAX_ROUNDS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_count,
  input  logic [CNT_W-1:0] value,
  output logic             count_done,
  output logic [CNT_W-1:0] bit_idx,
  input  logic             round_clear,
  input  logic [RND_W-1:0] rounds,
  input  logic             start_iteration,
  output logic             iteration_done,
  output logic [RND_W-1:0] round_idx,
  output logic             rc_bit
);

  localparam logic [RND_W-1:0] MAX_R = RND_W'(MAX_ROUNDS);

  logic [CNT_W-1:0] r_bit_idx;
  logic [RND_W-1:0] r_round_idx;
  logic [RND_W-1:0] r_rounds_q;
  logic             r_iter_done;

  logic [RND_W-1:0] w_round_next;
  logic [RND_W-1:0] w_rounds_sat;
  logic [7:0]       w_k;
  logic [7:0]       w_c;

  // value is compared live; a value lowered mid-phase lets the counter wrap
  assign count_done = start_count && (r_bit_idx == value);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_idx <= '0;
    end else if (!start_count || count_done) begin
      r_bit_idx <= '0;
    end else begin
      r_bit_idx <= r_bit_idx + CNT_W'(1);
    end
  end

  assign w_rounds_sat = ((rounds == '0) || (rounds > MAX_R)) ? MAX_R : rounds;

  always_comb begin
    w_round_next = r_round_idx;
    if (start_iteration && (r_round_idx < r_rounds_q)) begin
      w_round_next = r_round_idx + RND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_round_idx <= '0;
      r_rounds_q  <= MAX_R;
      r_iter_done <= 1'b0;
    end else if (round_clear) begin
      r_round_idx <= '0;
      r_rounds_q  <= w_rounds_sat;
      r_iter_done <= 1'b0;
    end else begin
      r_round_idx <= w_round_next;
      r_iter_done <= (w_round_next == r_rounds_q);
    end
  end

  // Shorter schedules use the tail of the full constant table
  assign w_k = 8'(MAX_ROUNDS) - 8'(r_rounds_q) + 8'(r_round_idx);
  assign w_c = (w_k >= 8'(MAX_ROUNDS)) ? 8'h00 : {4'hF - w_k[3:0], w_k[3:0]};

  assign rc_bit = ((r_bit_idx >> 3) == '0) ? w_c[3'd7 - r_bit_idx[2:0]] : 1'b0;

  assign bit_idx        = r_bit_idx;
  assign round_idx      = r_round_idx;
  assign iteration_done = r_iter_done;

endmodule
